// File: rtl/result_fifo.sv
// Result FIFO: buffers packed exponential results ({intt, frac, ui}) between
// the exponential wrapper and its downstream consumer. First-word-fall-through
// read port, registered status flags, sticky overflow/underflow indicators.
module result_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push_ok;
    logic             pop_ok;

    // Status flags come straight from the registered count so no request
    // input can reach them combinationally.
    assign full        = (count_q == CNT_FULL);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CNT_AF);
    assign count       = count_q;
    assign ovf         = ovf_q;
    assign udf         = udf_q;
    assign rd_data     = mem_q[rp_q];

    // A push into a full FIFO is still accepted when a pop frees the slot on
    // the same edge; the new word lands in the slot being vacated.
    assign pop_ok  = rd_req & ~empty;
    assign push_ok = wr_req & (~full | pop_ok);

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (push_ok) begin
            wp_d = wp_q + PTR_ONE;
        end
        if (pop_ok) begin
            rp_d = rp_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
        if (wr_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (rd_req && empty) begin
            udf_d = 1'b1;
        end
    end

    // Control state register; reset wins over any concurrent request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array; contents are not cleared on reset, only the write is
    // suppressed so a push coinciding with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_result_fifo.sv
// Self-checking bench for result_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_result_fifo;

    localparam int WIDTH = 21;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_req;
    logic [WIDTH-1:0] wr_data;
    logic             rd_req;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [AW:0]      count;
    logic             ovf;
    logic             udf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] mq[$];
    logic             m_ovf;
    logic             m_udf;

    result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .ovf         (ovf),
        .udf         (udf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rd);
        bit pop_ok, push_ok;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop_ok  = rd && (mq.size() > 0);
            push_ok = w && ((mq.size() < DEPTH) || pop_ok);
            if (rd && mq.size() == 0) m_udf = 1'b1;
            if (w && !push_ok) m_ovf = 1'b1;
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
    endtask

    task automatic check_flags(input string sfx);
        check({"count", sfx}, 32'(count), 32'(mq.size()));
        check({"empty", sfx}, 32'(empty), 32'(mq.size() == 0));
        check({"full", sfx}, 32'(full), 32'(mq.size() == DEPTH));
        check({"almost_full", sfx}, 32'(almost_full), 32'(mq.size() >= DEPTH - 1));
    endtask

    task automatic compare_all();
        check_flags("");
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("udf", 32'(udf), 32'(m_udf));
        if (mq.size() > 0) check("rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    // One clock: apply inputs, confirm flags do not react to them before the
    // edge, then advance the model and compare after the edge.
    task automatic cycle(input logic r, input logic w, input logic [WIDTH-1:0] d, input logic rd);
        rst = r; wr_req = w; wr_data = d; rd_req = rd;
        #1;
        if (!$isunknown(count)) check_flags("_pre");
        @(posedge clk);
        model_step(r, w, d, rd);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic reset_dut();
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int trace[6];
        int pw, pr;
        trace = '{1, 2, 3, 2, 1, 0};
        rst = 1'b1; wr_req = 1'b0; wr_data = '0; rd_req = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
        reset_dut();
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_count", 32'(count), 32'd0);

        // In-order basic push/pop with count trace
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, WIDTH'(i + 1), 1'b0);
            check("trace", 32'(count), 32'(trace[i]));
        end
        for (int i = 0; i < 3; i++) begin
            check("basic_rd", 32'(rd_data), 32'(i + 1));
            cycle(1'b0, 1'b0, '0, 1'b1);
            check("trace", 32'(count), 32'(trace[i + 3]));
        end
        check("basic_empty", 32'(empty), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, WIDTH'(32'h10000 + i), 1'b0);
            if (i == DEPTH - 2) check("af_at_7", 32'(almost_full), 32'd1);
        end
        check("full_at_8", 32'(full), 32'd1);
        cycle(1'b0, 1'b1, WIDTH'(32'h1FFFF), 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_rd", 32'(rd_data), 32'h10000 + i);
            cycle(1'b0, 1'b0, '0, 1'b1);
        end

        // Simultaneous push/pop while full
        reset_dut();
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        cycle(1'b0, 1'b1, WIDTH'(32'h0AAAA), 1'b1);
        check("full_pp_count", 32'(count), 32'd8);
        check("full_pp_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("full_pp_last", 32'(rd_data), 32'h0AAAA);
            cycle(1'b0, 1'b0, '0, 1'b1);
        end

        // Simultaneous push/pop while empty
        reset_dut();
        cycle(1'b0, 1'b1, WIDTH'(32'h15555), 1'b1);
        check("empty_pp_udf", 32'(udf), 32'd1);
        check("empty_pp_count", 32'(count), 32'd1);
        check("empty_pp_rd", 32'(rd_data), 32'h15555);

        // Pointer wrap ordering
        reset_dut();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, WIDTH'(32'h20 + i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("wrap_rd", 32'(rd_data), 32'h20 + i);
            cycle(1'b0, 1'b0, '0, 1'b1);
        end
        check("wrap_ovf", 32'(ovf), 32'd0);
        check("wrap_udf", 32'(udf), 32'd0);

        // Reset mid-operation with concurrent push
        reset_dut();
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, WIDTH'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check("pre_rst_count", 32'(count), 32'd4);
        check("pre_rst_ovf", 32'(ovf), 32'd1);
        cycle(1'b1, 1'b1, WIDTH'(32'h1234), 1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ovf", 32'(ovf), 32'd0);
        cycle(1'b0, 1'b1, WIDTH'(32'h0BEEF), 1'b0);
        check("post_rst_push", 32'(rd_data), 32'h0BEEF);
        check("post_rst_count", 32'(count), 32'd1);

        // Randomized traffic with shifting push/pop bias
        for (int blk = 0; blk < 20; blk++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 150; i++) begin
                cycle(($urandom_range(0, 299) == 0),
                      ($urandom_range(0, 99) < pw),
                      WIDTH'($urandom),
                      ($urandom_range(0, 99) < pr));
            end
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
